// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package regfile_pkg;
    localparam int WIDTH = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;

    localparam logic [AW-1:0] ZERO_REG = '0;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } wb_src_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of issue, write-back request and register-file port signals.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             issue_ready;

    // A transfer happens at a rising edge where valid && ready; requesters
    // hold valid, rd and data stable until ready and never withdraw.
    logic             req0_valid;
    logic [AW-1:0]    req0_rd;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;

    logic             req1_valid;
    logic [AW-1:0]    req1_rd;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic             RegWrite;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD;
    logic [NREG-1:0]  busy;

    // Round-robin pointer, exposed for observation.
    wb_src_t          last;

    modport master (
        output issue_valid, issue_rd,
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  issue_ready, req0_ready, req1_ready,
        input  RegWrite, A3, WD, busy, last
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output issue_ready, req0_ready, req1_ready,
        output RegWrite, A3, WD, busy, last
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; `last` remembers the most recent winner.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output wb_src_t    last
);
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == SRC1) ? 2'b01 : 2'b10;
        end
    end

    // Reset to SRC1 so source 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= SRC1;
        end else if (advance) begin
            last <= grant[1] ? SRC1 : SRC0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter with registered register-file port and pending-write busy bits.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    regfile_wb_arbiter_if.slave  bus
);
    logic [1:0]       grant;
    logic             xfer;
    wb_src_t          last;
    logic [AW-1:0]    win_rd;
    logic [WIDTH-1:0] win_data;

    logic             we_q;
    logic [AW-1:0]    a3_q;
    logic [WIDTH-1:0] wd_q;

    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_next;
    logic [NREG-1:0]  set_mask;
    logic [NREG-1:0]  clr_mask;
    logic             issue_ok;

    assign xfer = |grant;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     ({bus.req1_valid, bus.req0_valid}),
        .advance (xfer),
        .grant   (grant),
        .last    (last)
    );

    assign win_rd   = grant[1] ? bus.req1_rd   : bus.req0_rd;
    assign win_data = grant[1] ? bus.req1_data : bus.req0_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q <= 1'b0;
            a3_q <= '0;
            wd_q <= '0;
        end else if (xfer) begin
            we_q <= (win_rd != ZERO_REG);
            a3_q <= win_rd;
            wd_q <= win_data;
        end else begin
            we_q <= 1'b0;
        end
    end

    assign issue_ok = !busy_q[bus.issue_rd] || (bus.issue_rd == ZERO_REG);

    // Clear lands on the same edge the register file captures WD; a
    // coincident set of the same index wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.issue_valid && issue_ok && (bus.issue_rd != ZERO_REG)) begin
            set_mask[bus.issue_rd] = 1'b1;
        end
        if (we_q) begin
            clr_mask[a3_q] = 1'b1;
        end
        busy_next    = (busy_q & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.issue_ready = issue_ok;
    assign bus.RegWrite    = we_q;
    assign bus.A3          = a3_q;
    assign bus.WD          = wd_q;
    assign bus.busy        = busy_q;
    assign bus.last        = last;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for the write-back arbiter and busy scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             r0v;
        logic [AW-1:0]    r0rd;
        logic [WIDTH-1:0] r0d;
        logic             r1v;
        logic [AW-1:0]    r1rd;
        logic [WIDTH-1:0] r1d;
        logic             rdy0;
        logic             rdy1;
        logic             we;
        logic [AW-1:0]    a3;
        logic [WIDTH-1:0] wd;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic r0v, input logic [AW-1:0] r0rd, input logic [WIDTH-1:0] r0d,
        input logic r1v, input logic [AW-1:0] r1rd, input logic [WIDTH-1:0] r1d,
        input logic rdy0, input logic rdy1,
        input logic we, input logic [AW-1:0] a3, input logic [WIDTH-1:0] wd);
        vec_t v;
        v.r0v = r0v; v.r0rd = r0rd; v.r0d = r0d;
        v.r1v = r1v; v.r1rd = r1rd; v.r1d = r1d;
        v.rdy0 = rdy0; v.rdy1 = rdy1;
        v.we = we; v.a3 = a3; v.wd = wd;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.req0_valid  = 1'b0;
        bus.req0_rd     = '0;
        bus.req0_data   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_rd     = '0;
        bus.req1_data   = '0;
    endtask

    initial begin
        // Sequence starts right after reset with last=SRC1.
        vecs[0]  = mk(1'b1, 5'd5,  32'hAAAA_0000, 1'b1, 5'd6,  32'h5555_0000, 1'b1, 1'b0, 1'b1, 5'd5,  32'hAAAA_0000);
        vecs[1]  = mk(1'b1, 5'd5,  32'hAAAA_0000, 1'b1, 5'd6,  32'h5555_0000, 1'b0, 1'b1, 1'b1, 5'd6,  32'h5555_0000);
        vecs[2]  = mk(1'b1, 5'd5,  32'hAAAA_0000, 1'b1, 5'd6,  32'h5555_0000, 1'b1, 1'b0, 1'b1, 5'd5,  32'hAAAA_0000);
        vecs[3]  = mk(1'b1, 5'd5,  32'hAAAA_0000, 1'b1, 5'd6,  32'h5555_0000, 1'b0, 1'b1, 1'b1, 5'd6,  32'h5555_0000);
        vecs[4]  = mk(1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'h0000_3333, 1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_3333);
        vecs[5]  = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd3,  32'h0000_3333);
        vecs[6]  = mk(1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF);
        vecs[7]  = mk(1'b1, 5'd9,  32'h0000_0099, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0099);
        vecs[8]  = mk(1'b1, 5'd10, 32'h0000_000A, 1'b1, 5'd11, 32'h0000_000B, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_000B);
        vecs[9]  = mk(1'b1, 5'd10, 32'h0000_000A, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_000A);
        vecs[10] = mk(1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_000A);

        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_regwrite", 64'(bus.RegWrite), 64'h0);
        chk("reset_a3",       64'(bus.A3),       64'h0);
        chk("reset_wd",       64'(bus.WD),       64'h0);
        chk("reset_busy",     64'(bus.busy),     64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus.req0_valid = vecs[i].r0v;
            bus.req0_rd    = vecs[i].r0rd;
            bus.req0_data  = vecs[i].r0d;
            bus.req1_valid = vecs[i].r1v;
            bus.req1_rd    = vecs[i].r1rd;
            bus.req1_data  = vecs[i].r1d;
            #1;
            chk($sformatf("vec%0d_ready0", i), 64'(bus.req0_ready), 64'(vecs[i].rdy0));
            chk($sformatf("vec%0d_ready1", i), 64'(bus.req1_ready), 64'(vecs[i].rdy1));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regwrite", i), 64'(bus.RegWrite), 64'(vecs[i].we));
            chk($sformatf("vec%0d_a3", i),       64'(bus.A3),       64'(vecs[i].a3));
            chk($sformatf("vec%0d_wd", i),       64'(bus.WD),       64'(vecs[i].wd));
            chk($sformatf("vec%0d_busy", i),     64'(bus.busy),     64'h0);
        end

        // Reservation, blocked re-issue, then write-back clearing the bit.
        @(negedge clk);
        idle_inputs();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        #1;
        chk("issue7_ready", 64'(bus.issue_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("issue7_busy", 64'(bus.busy), 64'h80);
        @(negedge clk);
        #1;
        chk("reissue7_blocked", 64'(bus.issue_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("reissue7_busy", 64'(bus.busy), 64'h80);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.req1_valid  = 1'b1;
        bus.req1_rd     = 5'd7;
        bus.req1_data   = 32'h0000_1234;
        #1;
        chk("wb7_ready1", 64'(bus.req1_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("wb7_regwrite", 64'(bus.RegWrite), 64'h1);
        chk("wb7_a3",       64'(bus.A3),       64'h7);
        chk("wb7_wd",       64'(bus.WD),       64'h1234);
        chk("wb7_busy_n",   64'(bus.busy),     64'h80);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wb7_busy_n1",     64'(bus.busy),     64'h0);
        chk("wb7_regwrite_n1", 64'(bus.RegWrite), 64'h0);

        // Issue to x0 is always accepted and never reserves.
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        #1;
        chk("issue0_ready", 64'(bus.issue_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("issue0_busy", 64'(bus.busy), 64'h0);

        // Asynchronous reset mid-cycle with busy and a registered write live.
        @(negedge clk);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        bus.req0_valid  = 1'b1;
        bus.req0_rd     = 5'd8;
        bus.req0_data   = 32'h0000_0088;
        @(posedge clk);
        #1;
        chk("pre_rst_busy",     64'(bus.busy),     64'h10);
        chk("pre_rst_regwrite", 64'(bus.RegWrite), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_regwrite", 64'(bus.RegWrite), 64'h0);
        chk("mid_rst_a3",       64'(bus.A3),       64'h0);
        chk("mid_rst_wd",       64'(bus.WD),       64'h0);
        chk("mid_rst_busy",     64'(bus.busy),     64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        bus.req0_valid  = 1'b1;
        bus.req0_rd     = 5'd12;
        bus.req0_data   = 32'h0000_000C;
        bus.req1_valid  = 1'b1;
        bus.req1_rd     = 5'd13;
        bus.req1_data   = 32'h0000_000D;
        #1;
        chk("post_rst_ready0", 64'(bus.req0_ready), 64'h1);
        chk("post_rst_ready1", 64'(bus.req1_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("post_rst_regwrite", 64'(bus.RegWrite), 64'h1);
        chk("post_rst_a3",       64'(bus.A3),       64'hC);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
